// File: rtl/pipeline_sequencer_if.sv
// Shared types and the sequencer's bus to the rest of the datapath.
//   cpu_types_pkg : word_t counter width and PC source encodings.
//   pipeline_sequencer_if : status inputs (cache hits, hazard, branch/jump,
//     halt) and control outputs (PC/latch enables and flushes, fetch request,
//     halted flag, performance counters).
//   master modport: the sequencer.  slave modport: the datapath side.
package cpu_types_pkg;
   localparam int unsigned WORD_W  = 32;
   localparam int unsigned PCSEL_W = 2;

   typedef logic [WORD_W-1:0]  word_t;
   typedef logic [PCSEL_W-1:0] pc_sel_t;

   localparam pc_sel_t PC_SEQ    = 2'b00;
   localparam pc_sel_t PC_JUMP   = 2'b01;
   localparam pc_sel_t PC_BRANCH = 2'b10;
endpackage

interface pipeline_sequencer_if;
   import cpu_types_pkg::*;

   // status from caches, hazard unit and resolution logic
   logic    ihit;
   logic    dhit;
   logic    dmem_req;
   logic    load_use;
   logic    jump_id;
   logic    branch_mem;
   logic    halt_mem;

   // pipeline control
   logic    pc_en;
   pc_sel_t pc_sel;
   logic    ifid_en;
   logic    idex_en;
   logic    exmem_en;
   logic    memwb_en;
   logic    ifid_flush;
   logic    idex_flush;
   logic    exmem_flush;
   logic    memwb_flush;
   logic    imemREN;
   logic    halted;

   // performance counters
   word_t   cycle_count;
   word_t   istall_count;
   word_t   flush_count;

   modport master (
      input  ihit, dhit, dmem_req, load_use, jump_id, branch_mem, halt_mem,
      output pc_en, pc_sel, ifid_en, idex_en, exmem_en, memwb_en,
             ifid_flush, idex_flush, exmem_flush, memwb_flush,
             imemREN, halted, cycle_count, istall_count, flush_count
   );

   modport slave (
      output ihit, dhit, dmem_req, load_use, jump_id, branch_mem, halt_mem,
      input  pc_en, pc_sel, ifid_en, idex_en, exmem_en, memwb_en,
             ifid_flush, idex_flush, exmem_flush, memwb_flush,
             imemREN, halted, cycle_count, istall_count, flush_count
   );
endinterface

// File: rtl/pipeline_sequencer.sv
// Central stall/flush controller for the five-stage pipeline.
// Decides each cycle whether PC and the IF/ID, ID/EX, EX/MEM, MEM/WB latches
// advance, hold or bubble, selects the PC source, runs the halt drain
// (RUN -> DRAIN -> HALTED) and keeps cycle / I-stall / flush counters.
//   CLK : clock, rising edge
//   RST : synchronous active-high reset
//   seq : pipeline_sequencer_if.master (status in, control/counters out)
// Control outputs are combinational from inputs and state; halted and the
// counters are registered.
module pipeline_sequencer
   import cpu_types_pkg::*;
(
   input  logic                 CLK,
   input  logic                 RST,
   pipeline_sequencer_if.master seq
);

   typedef enum logic [1:0] {
      RUN    = 2'd0,
      DRAIN  = 2'd1,
      HALTED = 2'd2
   } state_t;

   state_t state_q;
   state_t state_d;

   logic   dstall;
   logic   istall_evt;
   logic   flush_evt;

   // data-side stall: MEM access outstanding
   assign dstall = seq.dmem_req & ~seq.dhit;

   // state register
   always_ff @(posedge CLK) begin
      if (RST) state_q <= RUN;
      else     state_q <= state_d;
   end

   // next-state logic; a halt is only accepted once the MEM access completes
   always_comb begin
      state_d = state_q;
      case (state_q)
         RUN:     if (seq.halt_mem && !dstall) state_d = DRAIN;
         DRAIN:   state_d = HALTED;
         HALTED:  state_d = HALTED;
         default: state_d = RUN;
      endcase
   end

   // output decode: strict priority in RUN, everything quiet otherwise
   always_comb begin
      seq.pc_en       = 1'b0;
      seq.pc_sel      = PC_SEQ;
      seq.ifid_en     = 1'b0;
      seq.idex_en     = 1'b0;
      seq.exmem_en    = 1'b0;
      seq.memwb_en    = 1'b0;
      seq.ifid_flush  = 1'b0;
      seq.idex_flush  = 1'b0;
      seq.exmem_flush = 1'b0;
      seq.memwb_flush = 1'b0;
      seq.imemREN     = 1'b0;
      istall_evt      = 1'b0;
      flush_evt       = 1'b0;

      if (state_q == RUN) begin
         seq.imemREN = 1'b1;
         if (dstall) begin
            // freeze everything upstream, bubble into WB
            seq.memwb_en    = 1'b1;
            seq.memwb_flush = 1'b1;
         end else if (seq.branch_mem) begin
            // squash the three younger instructions, including any jump in ID
            seq.pc_en       = 1'b1;
            seq.pc_sel      = PC_BRANCH;
            seq.ifid_en     = 1'b1;
            seq.idex_en     = 1'b1;
            seq.exmem_en    = 1'b1;
            seq.memwb_en    = 1'b1;
            seq.ifid_flush  = 1'b1;
            seq.idex_flush  = 1'b1;
            seq.exmem_flush = 1'b1;
            flush_evt       = 1'b1;
         end else if (seq.halt_mem) begin
            // let HALT retire, stop feeding younger work behind it
            seq.exmem_en    = 1'b1;
            seq.exmem_flush = 1'b1;
            seq.memwb_en    = 1'b1;
         end else if (seq.load_use) begin
            seq.idex_en     = 1'b1;
            seq.idex_flush  = 1'b1;
            seq.exmem_en    = 1'b1;
            seq.memwb_en    = 1'b1;
         end else if (seq.jump_id) begin
            // redirect wins over an I-miss; ifid_flush drops the stale fetch
            seq.pc_en       = 1'b1;
            seq.pc_sel      = PC_JUMP;
            seq.ifid_en     = 1'b1;
            seq.idex_en     = 1'b1;
            seq.exmem_en    = 1'b1;
            seq.memwb_en    = 1'b1;
            seq.ifid_flush  = 1'b1;
            flush_evt       = 1'b1;
         end else if (!seq.ihit) begin
            seq.ifid_en     = 1'b1;
            seq.ifid_flush  = 1'b1;
            seq.idex_en     = 1'b1;
            seq.exmem_en    = 1'b1;
            seq.memwb_en    = 1'b1;
            istall_evt      = 1'b1;
         end else begin
            seq.pc_en       = 1'b1;
            seq.ifid_en     = 1'b1;
            seq.idex_en     = 1'b1;
            seq.exmem_en    = 1'b1;
            seq.memwb_en    = 1'b1;
         end
      end
   end

   // halted flag: sticky once the drain cycle completes
   always_ff @(posedge CLK) begin
      if (RST)                  seq.halted <= 1'b0;
      else if (state_q == DRAIN) seq.halted <= 1'b1;
   end

   // performance counters, free-running with natural wrap
   always_ff @(posedge CLK) begin
      if (RST) begin
         seq.cycle_count  <= '0;
         seq.istall_count <= '0;
         seq.flush_count  <= '0;
      end else begin
         if (state_q != HALTED) seq.cycle_count  <= seq.cycle_count  + word_t'(1);
         if (istall_evt)        seq.istall_count <= seq.istall_count + word_t'(1);
         if (flush_evt)         seq.flush_count  <= seq.flush_count  + word_t'(1);
      end
   end

endmodule

// File: tb/tb_pipeline_sequencer.sv
// Directed testbench for pipeline_sequencer: reset, normal advance, I-miss,
// D-stall with pending branch, branch/jump collisions, load-use, halt drain
// and reset during drain.
module tb_pipeline_sequencer;
   import cpu_types_pkg::*;

   logic clk;
   logic rst;
   int   tests;
   int   failed;

   pipeline_sequencer_if bus ();

   pipeline_sequencer dut (
      .CLK (clk),
      .RST (rst),
      .seq (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // packed view of all combinational controls:
   // {pc_en, pc_sel[1:0], en{ifid,idex,exmem,memwb}, flush{same order}, imemREN}
   logic [11:0] ctl;
   assign ctl = {bus.pc_en, bus.pc_sel,
                 bus.ifid_en, bus.idex_en, bus.exmem_en, bus.memwb_en,
                 bus.ifid_flush, bus.idex_flush, bus.exmem_flush, bus.memwb_flush,
                 bus.imemREN};

   function automatic logic [11:0] mk(input logic pc, input logic [1:0] sel,
                                      input logic [3:0] en, input logic [3:0] fl,
                                      input logic im);
      return {pc, sel, en, fl, im};
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         failed++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic drive(input logic ih, input logic dh, input logic dr, input logic lu,
                        input logic j, input logic b, input logic h);
      bus.ihit       = ih;
      bus.dhit       = dh;
      bus.dmem_req   = dr;
      bus.load_use   = lu;
      bus.jump_id    = j;
      bus.branch_mem = b;
      bus.halt_mem   = h;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   logic [11:0] c_norm, c_imiss, c_dstall, c_branch, c_jump, c_lu, c_halt, c_idle;

   initial begin
      tests  = 0;
      failed = 0;
      c_norm   = mk(1'b1, 2'b00, 4'b1111, 4'b0000, 1'b1);
      c_imiss  = mk(1'b0, 2'b00, 4'b1111, 4'b1000, 1'b1);
      c_dstall = mk(1'b0, 2'b00, 4'b0001, 4'b0001, 1'b1);
      c_branch = mk(1'b1, 2'b10, 4'b1111, 4'b1110, 1'b1);
      c_jump   = mk(1'b1, 2'b01, 4'b1111, 4'b1000, 1'b1);
      c_lu     = mk(1'b0, 2'b00, 4'b0111, 4'b0100, 1'b1);
      c_halt   = mk(1'b0, 2'b00, 4'b0011, 4'b0010, 1'b1);
      c_idle   = mk(1'b0, 2'b00, 4'b0000, 4'b0000, 1'b0);

      // reset
      rst = 1'b1;
      drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      tick();
      tick();
      chk("rst_halted", 32'(bus.halted), 32'd0);
      chk("rst_cycle", bus.cycle_count, 32'd0);
      chk("rst_istall", bus.istall_count, 32'd0);
      chk("rst_flush", bus.flush_count, 32'd0);
      rst = 1'b0;

      // 10 clean cycles
      for (int i = 0; i < 10; i++) begin
         drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
         #1 chk("normal_ctl", 32'(ctl), 32'(c_norm));
         tick();
      end
      chk("normal_cycle", bus.cycle_count, 32'd10);
      chk("normal_istall", bus.istall_count, 32'd0);

      // 3 instruction misses
      for (int i = 0; i < 3; i++) begin
         drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
         #1 chk("imiss_ctl", 32'(ctl), 32'(c_imiss));
         tick();
      end
      chk("imiss_istall", bus.istall_count, 32'd3);
      drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      #1 chk("imiss_recover", 32'(ctl), 32'(c_norm));
      tick();
      chk("imiss_cycle", bus.cycle_count, 32'd14);

      // D-stall with a branch waiting behind it
      for (int i = 0; i < 4; i++) begin
         drive(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
         #1 chk("dstall_ctl", 32'(ctl), 32'(c_dstall));
         tick();
      end
      chk("dstall_noflush", bus.flush_count, 32'd0);
      drive(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
      #1 chk("dstall_branch", 32'(ctl), 32'(c_branch));
      tick();
      chk("dstall_flushcnt", bus.flush_count, 32'd1);
      chk("dstall_cycle", bus.cycle_count, 32'd19);

      // branch and jump together: branch wins, one flush event
      drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
      #1 chk("br_jmp_ctl", 32'(ctl), 32'(c_branch));
      tick();
      chk("br_jmp_flushcnt", bus.flush_count, 32'd2);

      // jump during I-miss: redirect taken, no I-stall counted
      drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
      #1 chk("jmp_miss_ctl", 32'(ctl), 32'(c_jump));
      tick();
      chk("jmp_miss_flushcnt", bus.flush_count, 32'd3);
      chk("jmp_miss_istall", bus.istall_count, 32'd3);

      // load-use bubble
      drive(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
      #1 chk("load_use_ctl", 32'(ctl), 32'(c_lu));
      tick();

      // halt held behind a D-stall, then accepted
      drive(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
      #1 chk("halt_dstall_ctl", 32'(ctl), 32'(c_dstall));
      tick();
      drive(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
      #1 chk("halt_still_run", 32'(ctl), 32'(c_halt));
      tick();
      drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      #1 chk("drain_ctl", 32'(ctl), 32'(c_idle));
      chk("drain_halted", 32'(bus.halted), 32'd0);
      tick();
      chk("halted_set", 32'(bus.halted), 32'd1);
      chk("halted_cycle", bus.cycle_count, 32'd25);

      // inputs toggled while halted have no effect
      for (int i = 0; i < 3; i++) begin
         drive(i[0], 1'b0, 1'b0, 1'b0, 1'b1, ~i[0], 1'b0);
         #1 chk("halted_ctl", 32'(ctl), 32'(c_idle));
         tick();
      end
      chk("halted_hold", 32'(bus.halted), 32'd1);
      chk("halted_cycle_frozen", bus.cycle_count, 32'd25);
      chk("halted_flush_frozen", bus.flush_count, 32'd3);
      chk("halted_istall_frozen", bus.istall_count, 32'd3);

      // reset asserted mid-drain
      rst = 1'b1;
      drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      tick();
      rst = 1'b0;
      chk("rerun_halted", 32'(bus.halted), 32'd0);
      drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
      #1 chk("rerun_halt_ctl", 32'(ctl), 32'(c_halt));
      tick();
      drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      #1 chk("rerun_drain_ctl", 32'(ctl), 32'(c_idle));
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk("drain_rst_halted", 32'(bus.halted), 32'd0);
      chk("drain_rst_cycle", bus.cycle_count, 32'd0);
      #1 chk("drain_rst_ctl", 32'(ctl), 32'(c_norm));
      tick();
      chk("post_rst_halted", 32'(bus.halted), 32'd0);
      chk("post_rst_cycle", bus.cycle_count, 32'd1);

      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end

endmodule
